// File: rtl/cd_pkg.sv
// Shared definitions for the RS485 bus scheduler.
//
// Contents:
//   DIV_W_DEF / GRD_W_DEF : default widths of the bit-divider and guard configs
//   cd_state_e            : scheduler state encoding
//   st_drives_bus()       : true in the states that own the RS485 driver
package cd_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int GRD_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_READY = 3'd1,
        ST_PRE   = 3'd2,
        ST_XMIT  = 3'd3,
        ST_POST  = 3'd4
    } cd_state_e;

    // The driver is enabled for the whole PRE..POST window. tx_gnt is only
    // ever raised in XMIT, so it cannot be high unless tx_en is high too.
    function automatic logic st_drives_bus(input cd_state_e s);
        return (s == ST_PRE) || (s == ST_XMIT) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/cd_bit_tick.sv
// Bit-time divider for the bus scheduler.
//
// Emits a one-cycle tick once every div+1 clocks. Holding restart high
// keeps the divider at phase 0 and suppresses the tick, so counting
// restarts cleanly once restart is released.
//
// Ports:
//   clk      in   sole clock
//   reset_n  in   asynchronous active-low reset
//   div      in   clocks per bit minus 1 (quasi-static)
//   restart  in   hold divider at phase 0
//   tick     out  one-cycle pulse at the end of each bit time
module cd_bit_tick
    import cd_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    // >= rather than == so a lowered div cannot strand the counter above it.
    assign wrap = (cnt >= div);
    assign tick = wrap && !restart;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cd_bus_sched.sv
// RS485 half-duplex bus scheduler.
//
// Watches the receive line for a run of idle bit-times before declaring the
// bus free, then hands the bus to the local serializer with a driver-enable
// guard window before and after the data.
//
// Ports:
//   clk         in   sole clock
//   reset_n     in   asynchronous active-low reset
//   rx          in   RS485 receive line, idle-high, asynchronous to clk
//   bit_div     in   clocks per bit minus 1
//   idle_wait   in   idle bit-times needed before the bus is free (0 acts as 1)
//   pre_guard   in   clocks tx_en leads tx_gnt, minus 1
//   post_guard  in   clocks tx_en trails tx_done, minus 1
//   tx_req      in   level request from the serializer
//   tx_done     in   one-cycle pulse: serializer sent its last bit
//   tx_gnt      out  serializer may shift data
//   tx_en       out  RS485 driver enable
//   bus_idle    out  bus is free
//
// state | meaning
// ------+-------------------------------------------------------------
// WAIT  | counting idle bit-times on rx; any low rx_s restarts the count
// READY | bus free, waiting for tx_req; rx activity sends us back to WAIT
// PRE   | driver on, guard time before data (tx_req drop aborts to POST)
// XMIT  | serializer owns the bus until tx_done
// POST  | driver held on for the trailing guard, rx ignored (own echo)
module cd_bus_sched
    import cd_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int GRD_W = GRD_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] bit_div,
    input  logic [GRD_W-1:0] idle_wait,
    input  logic [GRD_W-1:0] pre_guard,
    input  logic [GRD_W-1:0] post_guard,
    input  logic             tx_req,
    input  logic             tx_done,
    output logic             tx_gnt,
    output logic             tx_en,
    output logic             bus_idle
);

    // Synchronizer flops reset high so a reset does not look like rx activity.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    logic bit_tick;

    cd_bit_tick #(
        .DIV_W (DIV_W)
    ) u_bit_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (bit_div),
        .restart (!rx_s),
        .tick    (bit_tick)
    );

    cd_state_e        state,     state_nxt;
    logic [GRD_W-1:0] idle_cnt,  idle_nxt;
    logic [GRD_W-1:0] guard_cnt, guard_nxt;

    logic [GRD_W-1:0] idle_tgt;
    logic [GRD_W:0]   idle_inc;
    logic [GRD_W-1:0] idle_sat;
    logic             idle_reached;

    // One extra bit on the increment lets the compare see a would-be wrap and
    // lets the saturating value be taken without overflow.
    always_comb begin
        idle_tgt     = (idle_wait == '0) ? GRD_W'(1) : idle_wait;
        idle_inc     = {1'b0, idle_cnt} + 1'b1;
        idle_sat     = idle_inc[GRD_W] ? '1 : idle_inc[GRD_W-1:0];
        idle_reached = (idle_inc >= {1'b0, idle_tgt});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_WAIT;
            idle_cnt  <= '0;
            guard_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idle_cnt  <= idle_nxt;
            guard_cnt <= guard_nxt;
        end
    end

    // The idle count only survives while sitting in WAIT with rx_s high;
    // every other path clears it, so any re-entry to WAIT starts from zero.
    // Guard timers are loaded with the guard value on entry and count down,
    // leaving the state on the cycle they are seen at zero.
    always_comb begin
        state_nxt = state;
        idle_nxt  = '0;
        guard_nxt = guard_cnt;

        case (state)
            ST_WAIT: begin
                if (rx_s) begin
                    idle_nxt = idle_cnt;
                    if (bit_tick) begin
                        if (idle_reached) begin
                            state_nxt = ST_READY;
                        end else begin
                            idle_nxt = idle_sat;
                        end
                    end
                end
            end

            ST_READY: begin
                // rx activity wins over a simultaneous request.
                if (!rx_s) begin
                    state_nxt = ST_WAIT;
                end else if (tx_req) begin
                    state_nxt = ST_PRE;
                    guard_nxt = pre_guard;
                end
            end

            ST_PRE: begin
                if (!tx_req) begin
                    state_nxt = ST_POST;
                    guard_nxt = post_guard;
                end else if (guard_cnt == '0) begin
                    state_nxt = ST_XMIT;
                end else begin
                    guard_nxt = guard_cnt - 1'b1;
                end
            end

            ST_XMIT: begin
                if (tx_done) begin
                    state_nxt = ST_POST;
                    guard_nxt = post_guard;
                end
            end

            ST_POST: begin
                if (guard_cnt == '0) begin
                    state_nxt = ST_WAIT;
                end else begin
                    guard_nxt = guard_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = ST_WAIT;
                guard_nxt = '0;
            end
        endcase
    end

    // Outputs are pure decodes of the state register, so the asynchronous
    // reset drops tx_en/tx_gnt the moment reset_n falls.
    assign tx_en    = st_drives_bus(state);
    assign tx_gnt   = (state == ST_XMIT);
    assign bus_idle = (state == ST_READY);

endmodule

// File: tb/tb_cd_bus_sched.sv
module tb_cd_bus_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] bit_div = 16'd3;
    logic [7:0]  idle_wait = 8'd2;
    logic [7:0]  pre_guard = 8'd2;
    logic [7:0]  post_guard = 8'd1;
    logic        tx_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_gnt;
    logic        tx_en;
    logic        bus_idle;

    int n_total = 0;
    int n_pass  = 0;

    cd_bus_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .bit_div    (bit_div),
        .idle_wait  (idle_wait),
        .pre_guard  (pre_guard),
        .post_guard (post_guard),
        .tx_req     (tx_req),
        .tx_done    (tx_done),
        .tx_gnt     (tx_gnt),
        .tx_en      (tx_en),
        .bus_idle   (bus_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Tracks the bus by elapsed time: clocks since the divider last restarted,
    // completed idle bit-times, and cycles left in a guard window.
    typedef enum {M_WAIT, M_READY, M_PRE, M_XMIT, M_POST} m_phase_e;
    m_phase_e m_ph;
    bit       m_rx_d1, m_rx_s;
    int       m_age, m_idle, m_left;

    task automatic model_reset();
        m_ph = M_WAIT; m_rx_d1 = 1'b1; m_rx_s = 1'b1;
        m_age = 0; m_idle = 0; m_left = 0;
    endtask

    task automatic model_edge(input bit rx_i, input bit req_i, input bit done_i);
        bit rs;
        bit tick;
        int n;
        int target;
        rs     = m_rx_s;
        n      = int'(bit_div) + 1;
        tick   = rs && ((m_age % n) == n - 1);
        m_age  = rs ? m_age + 1 : 0;
        m_rx_s = m_rx_d1;
        m_rx_d1 = rx_i;
        target = (idle_wait == 8'd0) ? 1 : int'(idle_wait);
        case (m_ph)
            M_WAIT: begin
                if (!rs) m_idle = 0;
                else if (tick) begin
                    m_idle++;
                    if (m_idle >= target) begin m_ph = M_READY; m_idle = 0; end
                end
            end
            M_READY: begin
                if (!rs) begin m_ph = M_WAIT; m_idle = 0; end
                else if (req_i) begin m_ph = M_PRE; m_left = int'(pre_guard) + 1; end
            end
            M_PRE: begin
                if (!req_i) begin m_ph = M_POST; m_left = int'(post_guard) + 1; end
                else begin
                    m_left--;
                    if (m_left == 0) m_ph = M_XMIT;
                end
            end
            M_XMIT: begin
                if (done_i) begin m_ph = M_POST; m_left = int'(post_guard) + 1; end
            end
            M_POST: begin
                m_left--;
                if (m_left == 0) begin m_ph = M_WAIT; m_idle = 0; end
            end
            default: m_ph = M_WAIT;
        endcase
    endtask

    // ---------------- helpers ----------------
    // Leaves the bench at a falling edge, reset just released.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0; rx = 1'b1; tx_req = 1'b0; tx_done = 1'b0;
        model_reset();
        @(negedge clk);
        chk({tag, " reset tx_en"},    tx_en,    1'b0);
        chk({tag, " reset tx_gnt"},   tx_gnt,   1'b0);
        chk({tag, " reset bus_idle"}, bus_idle, 1'b0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit rx, req, done;
        bit en, gnt, idle;
    } vec_t;
    vec_t tbl[1:50];

    task automatic rows(input int lo, input int hi, input bit r, input bit q, input bit d,
                        input bit e, input bit g, input bit i);
        for (int k = lo; k <= hi; k++) tbl[k] = '{r, q, d, e, g, i};
    endtask

    initial begin
        // Row k: inputs held across the k-th rising edge after reset release,
        // expected outputs just after that edge. bit_div=3, idle_wait=2,
        // pre_guard=2, post_guard=1.
        rows( 1,  7, 1,0,0, 0,0,0);
        rows( 8,  8, 1,0,0, 0,0,1);   // 2 idle bits of 4 clocks
        rows( 9, 11, 1,1,0, 1,0,0);   // request: driver on at once
        rows(12, 13, 1,1,0, 1,1,0);   // grant 3 cycles later
        rows(14, 14, 1,1,1, 1,0,0);   // tx_done drops grant
        rows(15, 15, 1,0,0, 1,0,0);
        rows(16, 23, 1,0,0, 0,0,0);   // driver off 2 cycles after done
        rows(24, 24, 1,0,0, 0,0,1);
        rows(25, 25, 0,0,0, 0,0,1);   // 1-cycle rx low pulse
        rows(26, 26, 1,0,0, 0,0,1);
        rows(27, 34, 1,0,0, 0,0,0);   // falls 2 cycles after pulse
        rows(35, 35, 1,0,0, 0,0,1);   // back 8 clocks after rx_s high
        rows(36, 36, 0,0,0, 0,0,1);
        rows(37, 37, 1,0,0, 0,0,1);
        rows(38, 39, 1,1,0, 0,0,0);   // rx_s low and tx_req together
        rows(40, 45, 1,0,0, 0,0,0);
        rows(46, 46, 1,0,0, 0,0,1);
        rows(47, 47, 1,1,0, 1,0,0);
        rows(48, 49, 1,0,0, 1,0,0);   // request withdrawn in PRE
        rows(50, 50, 1,0,0, 0,0,0);

        bit_div = 16'd3; idle_wait = 8'd2; pre_guard = 8'd2; post_guard = 8'd1;
        do_reset("table");
        for (int k = 1; k <= 50; k++) begin
            rx = tbl[k].rx; tx_req = tbl[k].req; tx_done = tbl[k].done;
            @(posedge clk); #1;
            chk($sformatf("tbl[%0d] tx_en", k),    tx_en,    tbl[k].en);
            chk($sformatf("tbl[%0d] tx_gnt", k),   tx_gnt,   tbl[k].gnt);
            chk($sformatf("tbl[%0d] bus_idle", k), bus_idle, tbl[k].idle);
            @(negedge clk);
        end
        tx_req = 1'b0; tx_done = 1'b0; rx = 1'b1;

        // Asynchronous reset in the middle of XMIT.
        do_reset("async");
        for (int k = 0; k < 20 && !bus_idle; k++) @(negedge clk);
        chk("async reach ready", bus_idle, 1'b1);
        tx_req = 1'b1;
        for (int k = 0; k < 10 && !tx_gnt; k++) @(negedge clk);
        chk("async reach xmit", tx_gnt, 1'b1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("async tx_en drop",  tx_en,    1'b0);
        chk("async tx_gnt drop", tx_gnt,   1'b0);
        chk("async bus_idle",    bus_idle, 1'b0);
        @(negedge clk);
        reset_n = 1'b1; tx_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("async rewait %0d bus_idle", k), bus_idle, k == 8);
            chk($sformatf("async rewait %0d tx_en", k),    tx_en,    1'b0);
        end

        // idle_wait = 0 behaves as a single idle bit.
        idle_wait = 8'd0;
        do_reset("idle0");
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("idle0 edge %0d bus_idle", k), bus_idle, k == 4);
        end
        @(negedge clk);

        // Random configurations and traffic against the model.
        for (int t = 0; t < 40; t++) begin
            int quiet;
            bit_div    = 16'($urandom_range(0, 3));
            idle_wait  = 8'($urandom_range(0, 3));
            pre_guard  = 8'($urandom_range(0, 3));
            post_guard = 8'($urandom_range(0, 3));
            quiet      = int'($urandom_range(6, 40));
            do_reset($sformatf("rand%0d", t));
            for (int c = 0; c < 250; c++) begin
                bit e_en, e_gnt, e_idle;
                e_en   = (m_ph == M_PRE) || (m_ph == M_XMIT) || (m_ph == M_POST);
                e_gnt  = (m_ph == M_XMIT);
                e_idle = (m_ph == M_READY);
                chk($sformatf("rand%0d c%0d tx_en", t, c),    tx_en,    e_en);
                chk($sformatf("rand%0d c%0d tx_gnt", t, c),   tx_gnt,   e_gnt);
                chk($sformatf("rand%0d c%0d bus_idle", t, c), bus_idle, e_idle);
                rx = ($urandom_range(0, quiet - 1) != 0);
                if ($urandom_range(0, 7) == 0) tx_req = ~tx_req;
                tx_done = ($urandom_range(0, 5) == 0);
                @(posedge clk);
                model_edge(rx, tx_req, tx_done);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
